wb_gpio: RTL and testbench
==========================

WB_GPIO -- requirements
Module: wb_gpio

Interface
REQ-001 The block SHALL have parameter N_PINS, default 16, giving the number of GPIO pins (1..32).
REQ-002 The block SHALL have port clk_i, input, 1, the Wishbone clock.
REQ-003 The block SHALL have port rst_i, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port wb_cyc_i, input, 1, the bus cycle.
REQ-005 The block SHALL have port wb_stb_i, input, 1, the strobe.
REQ-006 The block SHALL have port wb_we_i, input, 1, write enable.
REQ-007 The block SHALL have port wb_adr_i, input, 32, the byte address; only bits [5:2] are decoded.
REQ-008 The block SHALL have port wb_dat_i, input, 32, write data.
REQ-009 The block SHALL have port wb_sel_i, input, 4, byte enables.
REQ-010 The block SHALL have port wb_dat_o, output, 32, read data.
REQ-011 The block SHALL have port wb_ack_o, output, 1, access acknowledge.
REQ-012 The block SHALL have port wb_err_o, output, 1, unmapped-access error.
REQ-013 The block SHALL have port wb_stall_o, output, 1, tied to 0.
REQ-014 The block SHALL have port gpio_i, input, N_PINS, asynchronous pin inputs.
REQ-015 The block SHALL have port gpio_o, output, N_PINS, output pin values.
REQ-016 The block SHALL have port gpio_oe_o, output, N_PINS, per-pin output enables (1 = drive).
REQ-017 The block SHALL have port irq_o, output, 1, a level interrupt.

Function
REQ-018 The block SHALL use this register map (offset, access): 0x00 IN RO; 0x04 OUT RW; 0x08 DIR RW; 0x0C SET WO (1 sets OUT bit); 0x10 CLR WO (1 clears OUT bit); 0x14 IRQ_EN RW; 0x18 IRQ_EDGE RW (1 = rising, 0 = falling); 0x1C IRQ_PEND R/W1C.
REQ-019 The block SHALL accept one access per cycle whenever wb_cyc_i & wb_stb_i is high, and SHALL assert wb_ack_o, registered, exactly one cycle later with read data valid in that same cycle.
REQ-020 Back-to-back accesses SHALL produce back-to-back ack pulses with no bubble.
REQ-021 An access to offsets 0x20..0x3C SHALL assert wb_err_o instead of wb_ack_o one cycle later, with no state change and read data 0.
REQ-022 When wb_cyc_i is low in the response cycle, the block SHALL suppress wb_ack_o and wb_err_o; a write already accepted SHALL still take effect.
REQ-023 Writes SHALL honour wb_sel_i per byte; bits at or above N_PINS SHALL be ignored on write and read as 0.
REQ-024 Reads of write-only offsets SHALL return 0.
REQ-025 gpio_i SHALL pass through a 2-flop synchronizer; a pin change before edge k SHALL be readable in IN from edge k+2.
REQ-026 Edge detection SHALL compare the synchronized value with its one-cycle-delayed copy; a qualifying edge SHALL set its IRQ_PEND bit at edge k+2 regardless of IRQ_EN or DIR.
REQ-027 If a W1C write and a new edge hit the same PEND bit in the same cycle, the set SHALL win.
REQ-028 irq_o SHALL equal the OR of (IRQ_PEND & IRQ_EN) and SHALL be driven from registers only.
REQ-029 gpio_o SHALL equal OUT, and gpio_oe_o SHALL equal DIR.

Reset
REQ-030 During reset, OUT, DIR, IRQ_EN and IRQ_PEND SHALL be 0, IRQ_EDGE SHALL be all-ones, and wb_ack_o, wb_err_o, wb_dat_o and irq_o SHALL be 0.
REQ-031 The synchronizer and delayed-copy flops SHALL reset to 0, so no PEND bit is set for pins held high at reset release.
REQ-032 Reset asserted mid-access SHALL drop any pending ack or err, and the access SHALL be lost.

Configuration
REQ-033 With WB_GPIO_IRQ_EN defined, the block SHALL implement interrupt logic per REQ-026..REQ-028.
REQ-034 With WB_GPIO_IRQ_EN undefined, offsets 0x14..0x1C SHALL ack, read 0 and ignore writes; irq_o SHALL be tied 0; and no edge-detect flops SHALL be built.

Structure
REQ-035 Package calsoc_gpio_pkg SHALL hold the register offset constants, the typedef for the 4-bit register index, and the IRQ_EDGE reset value.
REQ-036 Sub-module gpio_sync SHALL implement the per-pin 2-flop synchronizer plus delayed copy and provide rise/fall pulses.
REQ-037 The block SHALL be mapped on the crossbar at base 0x02000000 with mask 0xFFFFFFC0.

Verification
REQ-038 Scenario: write DIR=0x00FF, then OUT=0x1234 -> gpio_oe_o=0x00FF, gpio_o=0x1234, each write acked exactly 1 cycle after its strobe.
REQ-039 Scenario: OUT=0x0F0F, then SET=0x00F0, then CLR=0x000F -> OUT reads 0x0FF0.
REQ-040 Scenario: write OUT=0xFFFF with wb_sel_i=4'b0001 from OUT=0 -> OUT reads 0x00FF.
REQ-041 Scenario: IRQ_EN=0x0001, IRQ_EDGE=0x0001, then gpio_i[0] rises -> PEND[0]=1 and irq_o=1 at edge k+2; then W1C 0x0001 -> irq_o=0 next cycle.
REQ-042 Scenario: W1C of PEND[0] in the same cycle as a new rising edge on pin 0 -> PEND[0] stays 1.
REQ-043 Scenario: read offset 0x24 -> wb_err_o pulse with no ack; then two back-to-back reads of IN -> two consecutive ack cycles.

Source files
------------

// File: rtl/calsoc_gpio_pkg.sv
// Shared constants for the Wishbone GPIO block: register indices,
// reset values and crossbar placement.
package calsoc_gpio_pkg;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t REG_IN       = 4'h0;
  localparam reg_idx_t REG_OUT      = 4'h1;
  localparam reg_idx_t REG_DIR      = 4'h2;
  localparam reg_idx_t REG_SET      = 4'h3;
  localparam reg_idx_t REG_CLR      = 4'h4;
  localparam reg_idx_t REG_IRQ_EN   = 4'h5;
  localparam reg_idx_t REG_IRQ_EDGE = 4'h6;
  localparam reg_idx_t REG_PEND     = 4'h7;

  localparam logic [31:0] IRQ_EDGE_RST = 32'hFFFF_FFFF;

  localparam logic [31:0] GPIO_BASE = 32'h0200_0000;
  localparam logic [31:0] GPIO_MASK = 32'hFFFF_FFC0;

  function automatic logic [31:0] sel_mask(
    input logic [3:0] sel
  );
    return {{8{sel[3]}}, {8{sel[2]}},
            {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Per-pin 2-flop synchronizer with delayed copy and edge pulses.
// Edge logic only exists when WB_GPIO_IRQ_EN is defined.
module gpio_sync #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] sync,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

`ifdef WB_GPIO_IRQ_EN
  logic [N-1:0] dly;
  logic [2:0]   arm;

  // Edges are masked until the chain has filled after reset, so pins
  // already high at release do not look like fresh rising edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly <= '0;
      arm <= '0;
    end else begin
      dly <= sync;
      arm <= {arm[1:0], 1'b1};
    end
  end

  assign rise = arm[2] ? (sync & ~dly) : '0;
  assign fall = arm[2] ? (~sync & dly) : '0;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO: IN/OUT/DIR/SET/CLR plus optional edge interrupts
// built when WB_GPIO_IRQ_EN is defined.
module wb_gpio
  import calsoc_gpio_pkg::*;
#(
  parameter int N_PINS = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_stall_o,
  input  logic [N_PINS-1:0] gpio_i,
  output logic [N_PINS-1:0] gpio_o,
  output logic [N_PINS-1:0] gpio_oe_o,
  output logic              irq_o
);

  logic              req;
  logic              mapped;
  logic              wr;
  reg_idx_t          idx;
  logic [31:0]       bmask;
  logic [N_PINS-1:0] wm;
  logic [N_PINS-1:0] wd;

  assign req    = wb_cyc_i & wb_stb_i;
  assign idx    = reg_idx_t'(wb_adr_i[5:2]);
  assign mapped = ~wb_adr_i[5];
  assign wr     = req & wb_we_i & mapped;
  assign bmask  = sel_mask(wb_sel_i);
  assign wm     = bmask[N_PINS-1:0];
  assign wd     = wb_dat_i[N_PINS-1:0] & wm;

  logic [N_PINS-1:0] pin_s;
  logic [N_PINS-1:0] rise;
  logic [N_PINS-1:0] fall;

  gpio_sync #(.N(N_PINS)) u_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (gpio_i),
    .sync (pin_s),
    .rise (rise),
    .fall (fall)
  );

  logic [N_PINS-1:0] out_q;
  logic [N_PINS-1:0] dir_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      dir_q <= '0;
    end else if (wr) begin
      unique case (idx)
        REG_OUT: out_q <= (out_q & ~wm) | wd;
        REG_SET: out_q <= out_q | wd;
        REG_CLR: out_q <= out_q & ~wd;
        REG_DIR: dir_q <= (dir_q & ~wm) | wd;
        default: ;
      endcase
    end
  end

`ifdef WB_GPIO_IRQ_EN
  logic [N_PINS-1:0] en_q;
  logic [N_PINS-1:0] edge_q;
  logic [N_PINS-1:0] pend_q;
  logic [N_PINS-1:0] hit;
  logic [N_PINS-1:0] w1c;

  assign hit = (rise & edge_q) | (fall & ~edge_q);
  assign w1c = (wr && idx == REG_PEND) ? wd : '0;

  // A new edge outranks a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= '0;
      edge_q <= IRQ_EDGE_RST[N_PINS-1:0];
      pend_q <= '0;
    end else begin
      if (wr && idx == REG_IRQ_EN)
        en_q <= (en_q & ~wm) | wd;
      if (wr && idx == REG_IRQ_EDGE)
        edge_q <= (edge_q & ~wm) | wd;
      pend_q <= (pend_q & ~w1c) | hit;
    end
  end

  assign irq_o = |(pend_q & en_q);
`else
  assign irq_o = 1'b0;
`endif

  logic [N_PINS-1:0] rd;
  logic [31:0]       rdata;

  always_comb begin
    rd = '0;
    unique case (idx)
      REG_IN:       rd = pin_s;
      REG_OUT:      rd = out_q;
      REG_DIR:      rd = dir_q;
`ifdef WB_GPIO_IRQ_EN
      REG_IRQ_EN:   rd = en_q;
      REG_IRQ_EDGE: rd = edge_q;
      REG_PEND:     rd = pend_q;
`endif
      default:      rd = '0;
    endcase
    rdata = '0;
    rdata[N_PINS-1:0] = rd;
  end

  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req & mapped;
      err_q <= req & ~mapped;
      dat_q <= (req & mapped & ~wb_we_i) ? rdata : '0;
    end
  end

  // A master that abandons the cycle gets no response.
  assign wb_ack_o   = ack_q & wb_cyc_i;
  assign wb_err_o   = err_q & wb_cyc_i;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign gpio_o     = out_q;
  assign gpio_oe_o  = dir_q;

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:6], wb_adr_i[1:0],
                         wb_dat_i, bmask, rise, fall};

endmodule

// File: tb/tb_wb_gpio.sv
// Scoreboard bench for wb_gpio: directed bus traffic, queued expectations,
// and a monitor that checks every response cycle.
module tb_wb_gpio;

  localparam int N = 16;
`ifdef WB_GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc, wb_stb, wb_we;
  logic [31:0]   wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]    wb_sel;
  logic          wb_ack, wb_err, wb_stall;
  logic [N-1:0]  gpio_in, gpio_out, gpio_oe;
  logic          irq;

  wb_gpio #(.N_PINS(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat_w),
    .wb_sel_i   (wb_sel),
    .wb_dat_o   (wb_dat_r),
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .wb_stall_o (wb_stall),
    .gpio_i     (gpio_in),
    .gpio_o     (gpio_out),
    .gpio_oe_o  (gpio_oe),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  typedef struct {
    int          due;
    bit          err;
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0 && q[0].due <= cyc_n) begin
      e = q.pop_front();
      checks++;
      if (e.due != cyc_n || wb_ack !== ~e.err || wb_err !== e.err ||
          (e.chk && wb_dat_r !== e.data)) begin
        fails++;
        $display("FAIL %s: ack=%b err=%b dat=%h cyc=%0d, want ack=%b err=%b dat=%h cyc=%0d",
                 e.name, wb_ack, wb_err, wb_dat_r, cyc_n,
                 ~e.err, e.err, e.data, e.due);
      end else begin
        passes++;
      end
    end else if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
      checks++;
      fails++;
      $display("FAIL spurious_resp: ack=%b err=%b at cyc=%0d, want none",
               wb_ack, wb_err, cyc_n);
    end
  end

  task automatic bus(input bit we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input bit err, input bit chk,
                     input logic [31:0] data, input string name);
    exp_t e;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
    e.due = cyc_n + 1; e.err = err; e.chk = chk;
    e.data = data; e.name = name;
    q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input string name);
    bus(1'b1, adr, dat, sel, 1'b0, 1'b0, 32'h0, name);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp,
                    input string name);
    bus(1'b0, adr, 32'h0, 4'hF, 1'b0, 1'b1, exp, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat_w = '0; wb_sel = 4'h0;
    gpio_in = 16'h8000;

    repeat (3) @(negedge clk);
    check("rst_gpio_o",  32'(gpio_out), 32'h0);
    check("rst_gpio_oe", 32'(gpio_oe),  32'h0);
    check("rst_ack_err", {30'h0, wb_ack, wb_err}, 32'h0);
    check("rst_dat",     wb_dat_r,      32'h0);
    check("rst_irq",     32'(irq),      32'h0);
    rst = 1'b0;
    idle(4);

    rd(32'h1C, 32'h0, "pend_after_rst");
    rd(32'h18, IRQ ? 32'h0000FFFF : 32'h0, "edge_rst");
    rd(32'h00, 32'h8000, "in_rst_high");

    wr(32'h08, 32'h00FF, 4'hF, "w_dir");
    wr(32'h04, 32'h1234, 4'hF, "w_out");
    idle(1);
    check("gpio_oe_dir", 32'(gpio_oe),  32'h00FF);
    check("gpio_o_out",  32'(gpio_out), 32'h1234);

    wr(32'h04, 32'h0F0F, 4'hF, "w_out2");
    wr(32'h0C, 32'h00F0, 4'hF, "w_set");
    wr(32'h10, 32'h000F, 4'hF, "w_clr");
    rd(32'h04, 32'h0FF0, "r_set_clr");
    rd(32'h0C, 32'h0,    "r_set_wo");
    rd(32'h10, 32'h0,    "r_clr_wo");

    wr(32'h04, 32'h0,    4'hF, "w_out0");
    wr(32'h04, 32'hFFFF, 4'h1, "w_sel1");
    rd(32'h04, 32'h00FF, "r_sel1");
    wr(32'h04, 32'hFFFF_FFFF, 4'hF, "w_wide");
    rd(32'h04, 32'h0000_FFFF, "r_wide");

    wr(32'h14, 32'h0001, 4'hF, "w_irq_en");
    wr(32'h18, 32'h0001, 4'hF, "w_irq_edge");
    rd(32'h14, IRQ ? 32'h1 : 32'h0, "r_irq_en");
    idle(1);
    gpio_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check("irq_k1", 32'(irq), 32'h0);
    @(posedge clk); #2;
    check("irq_k2", 32'(irq), IRQ ? 32'h1 : 32'h0);
    rd(32'h1C, IRQ ? 32'h1 : 32'h0, "r_pend_rise");
    wr(32'h1C, 32'h0001, 4'hF, "w_w1c");
    idle(1);
    check("irq_w1c", 32'(irq), 32'h0);

    idle(4);
    gpio_in[0] = 1'b0;
    idle(4);
    rd(32'h1C, 32'h0, "r_pend_fall");
    gpio_in[0] = 1'b1;
    idle(1);
    wr(32'h1C, 32'h0001, 4'hF, "w_w1c_race");
    rd(32'h1C, IRQ ? 32'h1 : 32'h0, "r_set_wins");
    idle(1);
    check("irq_set_wins", 32'(irq), IRQ ? 32'h1 : 32'h0);
    wr(32'h1C, 32'h0001, 4'hF, "w_w1c2");
    rd(32'h1C, 32'h0, "r_pend_clr");

    bus(1'b0, 32'h24, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, "r_err");
    rd(32'h00, 32'h8001, "r_in_a");
    rd(32'h00, 32'h8001, "r_in_b");
    bus(1'b1, 32'h20, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, "w_err");
    rd(32'h04, 32'hFFFF, "r_out_noerr");
    rd(32'h0200_0004, 32'hFFFF, "r_base");

    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 32'h04; wb_dat_w = 32'h5A5A; wb_sel = 4'hF;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rd(32'h04, 32'h5A5A, "r_abandon");

    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 32'h04; wb_dat_w = 32'h1111; wb_sel = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #2;
    check("rst_mid_ack", {30'h0, wb_ack, wb_err}, 32'h0);
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rst = 1'b0;
    check("rst2_gpio_o",  32'(gpio_out), 32'h0);
    check("rst2_gpio_oe", 32'(gpio_oe),  32'h0);
    idle(4);
    rd(32'h04, 32'h0, "r_out_rst2");
    rd(32'h18, IRQ ? 32'h0000FFFF : 32'h0, "r_edge_rst2");
    rd(32'h1C, 32'h0, "r_pend_rst2");
    idle(1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d responses missing, want 0", q.size());
      q.delete();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
